// File: rtl/instr_decode_issue_pkg.sv
// rtl/instr_decode_issue_pkg.sv - shared constants, opcode helpers and issue bundle type
package instr_decode_issue_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR   = $clog2(NUM_REGS);
    localparam int WORD_SIZE  = 19;
    localparam int OPC_SIZE   = 5;
    localparam int INSTR_SIZE = 19;

    // Instruction field LSBs: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] ignored
    localparam int OPC_LSB = 14;
    localparam int RD_LSB  = 11;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 5;

    typedef enum logic [OPC_SIZE-1:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_INC = 5'd4,
        OP_DEC = 5'd5,
        OP_AND = 5'd6,
        OP_OR  = 5'd7,
        OP_XOR = 5'd8,
        OP_NOT = 5'd9
    } opcode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic [OPC_SIZE-1:0]  alu_control;
        logic [WORD_SIZE-1:0] data_1;
        logic [WORD_SIZE-1:0] data_2;
        logic [REG_ADDR-1:0]  dest;
    } issue_bundle_t;

    function automatic logic is_legal(input logic [OPC_SIZE-1:0] opc);
        return opc <= OP_NOT;
    endfunction

    // Unary ops have no second source: rs2 neither hazards nor feeds reg_data_2
    function automatic logic is_unary(input logic [OPC_SIZE-1:0] opc);
        return (opc == OP_INC) || (opc == OP_DEC) || (opc == OP_NOT);
    endfunction

endpackage

// File: rtl/instr_decode_issue_reg_file.sv
// rtl/instr_decode_issue_reg_file.sv - 8x19 register file, 2 async reads, 1 sync write with bypass
module instr_decode_issue_reg_file
    import instr_decode_issue_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_ADDR-1:0]  i_rd_addr_1,
    input  logic [REG_ADDR-1:0]  i_rd_addr_2,
    output logic [WORD_SIZE-1:0] o_rd_data_1,
    output logic [WORD_SIZE-1:0] o_rd_data_2,
    input  logic                 i_wr_en,
    input  logic [REG_ADDR-1:0]  i_wr_addr,
    input  logic [WORD_SIZE-1:0] i_wr_data
);

    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

    // Storage: synchronous clear, single write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // A same-cycle write is forwarded so the issuing op sees the fresh value
    assign o_rd_data_1 = (i_wr_en && (i_wr_addr == i_rd_addr_1)) ? i_wr_data : r_regs[i_rd_addr_1];
    assign o_rd_data_2 = (i_wr_en && (i_wr_addr == i_rd_addr_2)) ? i_wr_data : r_regs[i_rd_addr_2];

endmodule

// File: rtl/instr_decode_issue.sv
// rtl/instr_decode_issue.sv - decode/issue stage with scoreboard hazard stall ahead of the ALU
module instr_decode_issue
    import instr_decode_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_SIZE-1:0] instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPC_SIZE-1:0]   ALU_control,
    output logic [WORD_SIZE-1:0]  reg_data_1,
    output logic [WORD_SIZE-1:0]  reg_data_2,
    output logic [REG_ADDR-1:0]   dest_addr,
    input  logic                  wb_en,
    input  logic [REG_ADDR-1:0]   wb_addr,
    input  logic [WORD_SIZE-1:0]  wb_data,
    output logic                  illegal_op
);

    state_e                r_state;
    state_e                w_state_next;
    logic [INSTR_SIZE-1:0] r_hold_instr;
    logic [NUM_REGS-1:0]   r_busy;
    issue_bundle_t         r_out;
    logic                  r_out_valid;
    logic                  r_illegal;

    logic [INSTR_SIZE-1:0] w_cur_instr;
    logic [OPC_SIZE-1:0]   w_opc;
    logic [REG_ADDR-1:0]   w_rd;
    logic [REG_ADDR-1:0]   w_rs1;
    logic [REG_ADDR-1:0]   w_rs2;
    logic                  w_unary;
    logic                  w_legal;
    logic [NUM_REGS-1:0]   w_wb_mask;
    logic [NUM_REGS-1:0]   w_busy_eff;
    logic [NUM_REGS-1:0]   w_issue_mask;
    logic                  w_hazard;
    logic                  w_slot_free;
    logic                  w_issue;
    logic                  w_hold_load;
    logic                  w_illegal_acc;
    logic [WORD_SIZE-1:0]  w_rd_data_1;
    logic [WORD_SIZE-1:0]  w_rd_data_2;
    logic                  w_unused_bits;

    // While stalled the held instruction is the one being checked; otherwise the fetch word
    assign w_cur_instr   = (r_state == ST_STALL) ? r_hold_instr : instr;
    assign w_opc         = w_cur_instr[OPC_LSB +: OPC_SIZE];
    assign w_rd          = w_cur_instr[RD_LSB  +: REG_ADDR];
    assign w_rs1         = w_cur_instr[RS1_LSB +: REG_ADDR];
    assign w_rs2         = w_cur_instr[RS2_LSB +: REG_ADDR];
    assign w_unused_bits = ^w_cur_instr[RS2_LSB-1:0];
    assign w_unary       = is_unary(w_opc);
    assign w_legal       = is_legal(w_opc);

    // Writeback this cycle releases its register before the hazard check
    assign w_wb_mask    = {{(NUM_REGS-1){1'b0}}, wb_en} << wb_addr;
    assign w_issue_mask = {{(NUM_REGS-1){1'b0}}, w_issue} << w_rd;
    assign w_busy_eff   = r_busy & ~w_wb_mask;
    assign w_hazard     = w_busy_eff[w_rs1] | (!w_unary & w_busy_eff[w_rs2]) | w_busy_eff[w_rd];
    assign w_slot_free  = !r_out_valid | out_ready;

    instr_decode_issue_reg_file u_reg_file (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_addr_1 (w_rs1),
        .i_rd_addr_2 (w_rs2),
        .o_rd_data_1 (w_rd_data_1),
        .o_rd_data_2 (w_rd_data_2),
        .i_wr_en     (wb_en),
        .i_wr_addr   (wb_addr),
        .i_wr_data   (wb_data)
    );

    // FSM next state and issue decisions
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_hold_load   = 1'b0;
        w_illegal_acc = 1'b0;
        in_ready      = 1'b0;
        case (r_state)
            ST_RUN: begin
                in_ready = w_slot_free;
                if (in_valid && w_slot_free) begin
                    if (!w_legal) begin
                        w_illegal_acc = 1'b1;
                    end else if (!w_hazard) begin
                        w_issue = 1'b1;
                    end else begin
                        w_hold_load  = 1'b1;
                        w_state_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!w_hazard && w_slot_free) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Hold register captures a hazarded instruction at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_instr <= '0;
        end else if (w_hold_load) begin
            r_hold_instr <= instr;
        end
    end

    // Scoreboard: writeback clears, issue sets; set applied last so it wins on the same rd
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wb_mask) | w_issue_mask;
        end
    end

    // Output register: loads only on issue, which requires a free slot, so a stalled bundle holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= w_illegal_acc;
            if (w_issue) begin
                r_out_valid       <= 1'b1;
                r_out.alu_control <= w_opc;
                r_out.data_1      <= w_rd_data_1;
                r_out.data_2      <= w_unary ? '0 : w_rd_data_2;
                r_out.dest        <= w_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign ALU_control = r_out.alu_control;
    assign reg_data_1  = r_out.data_1;
    assign reg_data_2  = r_out.data_2;
    assign dest_addr   = r_out.dest;
    assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_instr_decode_issue.sv
// tb/tb_instr_decode_issue.sv - self-checking bench for instr_decode_issue
module tb_instr_decode_issue;
    import instr_decode_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ALU_control;
    logic [18:0] reg_data_1;
    logic [18:0] reg_data_2;
    logic [2:0]  dest_addr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [18:0] wb_data;
    logic        illegal_op;

    instr_decode_issue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_control (ALU_control),
        .reg_data_1  (reg_data_1),
        .reg_data_2  (reg_data_2),
        .dest_addr   (dest_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        exp_valid;
        logic [18:0] exp_d1;
        logic [18:0] exp_d2;
    } vec_t;

    vec_t        vecs [8];
    logic [18:0] m_rf [8];
    logic [18:0] exp_q [$];
    int          pending [$];
    logic        prev_valid, prev_ready, exp_ill, acc, drain;
    logic [45:0] prev_bundle, cur_bundle;
    logic [18:0] w;
    int          idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] mk(input logic [4:0] opc, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {opc, rd, rs1, rs2, 5'b0};
    endfunction

    function automatic logic tb_unary(input logic [4:0] opc);
        return (opc == OP_INC) || (opc == OP_DEC) || (opc == OP_NOT);
    endfunction

    task automatic do_wb(input logic [2:0] a, input logic [18:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc();
        wb_en = 1'b0;
    endtask

    task automatic chk_bundle(input string name, input logic [4:0] alu, input logic [18:0] d1,
                              input logic [18:0] d2, input logic [2:0] dst);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_alu"}, ALU_control, alu);
        chk({name, "_d1"}, reg_data_1, d1);
        chk({name, "_d2"}, reg_data_2, d2);
        chk({name, "_dest"}, dest_addr, dst);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{OP_ADD, 3'd0, 3'd1, 3'd2, 1'b1, 19'h20, 19'h30};
        vecs[1] = '{OP_INC, 3'd1, 3'd7, 3'd3, 1'b1, 19'h80, 19'h0};
        vecs[2] = '{OP_MUL, 3'd2, 3'd0, 3'd0, 1'b1, 19'h10, 19'h10};
        vecs[3] = '{OP_XOR, 3'd3, 3'd6, 3'd5, 1'b1, 19'h70, 19'h60};
        vecs[4] = '{OP_DEC, 3'd4, 3'd4, 3'd4, 1'b1, 19'h50, 19'h0};
        vecs[5] = '{5'd20,  3'd5, 3'd1, 3'd2, 1'b0, 19'h0,  19'h0};
        vecs[6] = '{OP_NOT, 3'd6, 3'd2, 3'd7, 1'b1, 19'h30, 19'h0};
        vecs[7] = '{OP_DIV, 3'd7, 3'd3, 3'd1, 1'b1, 19'h40, 19'h20};

        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        cyc(); cyc();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_illegal", illegal_op, 1'b0);
        chk("reset_bundle", {ALU_control, reg_data_1, reg_data_2, dest_addr}, 46'h0);
        chk("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Basic issue: r1=10, r2=5, ADD r3 = r1, r2
        do_wb(3'd1, 19'd10);
        do_wb(3'd2, 19'd5);
        instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2); in_valid = 1'b1;
        #1 chk("add_in_ready", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        chk_bundle("add", OP_ADD, 19'd10, 19'd5, 3'd3);

        // RAW on r3: stalls until r3 writes back, then issues with the bypassed value
        instr = mk(OP_SUB, 3'd4, 3'd3, 3'd2); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("raw_stall_ready_0", in_ready, 1'b0);
        chk("raw_stall_valid_0", out_valid, 1'b0);
        cyc();
        chk("raw_stall_ready_1", in_ready, 1'b0);
        chk("raw_stall_valid_1", out_valid, 1'b0);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 19'd15;
        #1 chk("raw_wb_cycle_ready", in_ready, 1'b0);
        cyc(); wb_en = 1'b0;
        chk_bundle("raw", OP_SUB, 19'd15, 19'd5, 3'd4);
        chk("raw_back_to_run", in_ready, 1'b1);

        // Unary NOT with busy rs2 (r4) must not stall and zeroes operand 2
        do_wb(3'd1, 19'h2AAAA);
        instr = mk(OP_NOT, 3'd5, 3'd1, 3'd4); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk_bundle("unary", OP_NOT, 19'h2AAAA, 19'h0, 3'd5);

        // Backpressure: bundle holds 3 cycles, then next instr issues right after release
        out_ready = 1'b0;
        instr = mk(OP_ADD, 3'd6, 3'd1, 3'd2); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", in_ready, 1'b0);
            cyc();
            chk_bundle("bp_hold", OP_NOT, 19'h2AAAA, 19'h0, 3'd5);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        chk_bundle("bp_next", OP_ADD, 19'h2AAAA, 19'd5, 3'd6);

        // Illegal opcode: single pulse, no issue, rd=7 not marked busy
        instr = mk(5'b11111, 3'd7, 3'd0, 3'd0); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("ill_pulse", illegal_op, 1'b1);
        chk("ill_no_issue", out_valid, 1'b0);
        cyc();
        chk("ill_pulse_end", illegal_op, 1'b0);
        chk("ill_no_issue_1", out_valid, 1'b0);
        instr = mk(OP_ADD, 3'd7, 3'd7, 3'd7); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk_bundle("ill_sb_clear", OP_ADD, 19'h0, 19'h0, 3'd7);

        // Reset while stalled on busy r7
        instr = mk(OP_ADD, 3'd0, 3'd7, 3'd1); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("rst_stall_ready", in_ready, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        for (int r = 0; r < 8; r++) begin
            instr = mk(OP_ADD, 3'(r), 3'(r), 3'(r)); in_valid = 1'b1;
            cyc();
            chk_bundle("rst_clear", OP_ADD, 19'h0, 19'h0, 3'(r));
        end
        in_valid = 1'b0;

        // Table: preload r[i]=0x10*(i+1), issue each vector, then write rd back to free it
        for (int i = 0; i < 8; i++) do_wb(3'(i), 19'(16 * (i + 1)));
        for (int i = 0; i < 8; i++) begin
            instr = mk(vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].rs2); in_valid = 1'b1;
            cyc(); in_valid = 1'b0;
            chk("tbl_valid", out_valid, vecs[i].exp_valid);
            chk("tbl_illegal", illegal_op, !vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                chk_bundle("tbl", vecs[i].opc, vecs[i].exp_d1, vecs[i].exp_d2, vecs[i].rd);
            do_wb(vecs[i].rd, 19'(16 * (vecs[i].rd + 1)));
        end

        // Randomised traffic against a transaction-level model
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; exp_ill = 1'b0; acc = 1'b0;
        prev_bundle = '0;
        for (int c = 0; c < 2400; c++) begin
            drain = (c >= 2000);
            cur_bundle = {ALU_control, reg_data_1, reg_data_2, dest_addr};
            chk("rand_illegal", illegal_op, exp_ill);
            if (out_valid && (!prev_valid || prev_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_issue", 1'b1, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("rand_alu", ALU_control, w[18:14]);
                    chk("rand_d1", reg_data_1, m_rf[w[10:8]]);
                    chk("rand_d2", reg_data_2, tb_unary(w[18:14]) ? 19'h0 : m_rf[w[7:5]]);
                    chk("rand_dest", dest_addr, w[13:11]);
                end
            end else if (out_valid && prev_valid && !prev_ready) begin
                chk("rand_hold", cur_bundle, prev_bundle);
            end
            prev_valid  = out_valid;
            prev_bundle = cur_bundle;

            if (acc) in_valid = 1'b0;
            wb_en = 1'b0;
            out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (pending.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
                idx = $urandom_range(0, pending.size() - 1);
                wb_en = 1'b1;
                wb_addr = 3'(pending[idx]);
                wb_data = 19'($urandom);
                m_rf[wb_addr] = wb_data;
                pending.delete(idx);
            end
            if (!in_valid && !drain && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                instr = mk(($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31))
                                                       : 5'($urandom_range(0, 9)),
                           3'($urandom), 3'($urandom), 3'($urandom));
            end
            #1;
            acc = in_valid && in_ready;
            exp_ill = acc && (instr[18:14] > 5'd9);
            if (acc && instr[18:14] <= 5'd9) exp_q.push_back(instr);
            if (out_valid && out_ready) pending.push_back(int'(dest_addr));
            prev_ready = out_ready;
            cyc();
        end
        chk("rand_drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
